fpu_issue_sched: RTL and testbench

- Successor to the combinational FPU decoder.
- Decodes funct3/funct7 into fpucontrol, fpusrca and mode, and adds an issue handshake.
- Each op class has a parametrised latency. A writeback reservation shift register guarantees at most one FPU result per cycle. Iterative div/sqrt are single-occupancy.
- Sits between the core decode stage and the FPU datapath, and drives the FPU writeback mux.

---
 rtl/fpu_pkg.sv | 39 +++
 rtl/fpu_op_decode.sv | 38 +++
 rtl/fpu_issue_sched.sv | 112 +++++++++++
 tb/tb_fpu_issue_sched.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: FPU decode constants, op codes, writeback slot type and per-op latency lookup.
package fpu_pkg;
    localparam logic [6:0] F7_FADD   = 7'b0000000;
    localparam logic [6:0] F7_FSUB   = 7'b0000100;
    localparam logic [6:0] F7_FMUL   = 7'b0001000;
    localparam logic [6:0] F7_FDIV   = 7'b0001100;
    localparam logic [6:0] F7_FSQRT  = 7'b0101100;
    localparam logic [6:0] F7_FCVTWS = 7'b1100000;
    localparam logic [6:0] F7_FCMP   = 7'b1010000;
    localparam logic [6:0] F7_FCVTSW = 7'b1101000;
    localparam logic [2:0] F3_FEQ    = 3'b010;
    localparam logic [2:0] F3_FLT    = 3'b001;
    localparam logic [2:0] F3_FLE    = 3'b000;
    localparam int TAGW_MAX = 5;

    typedef enum logic [3:0] {
        FC_ADD, FC_SUB, FC_MUL, FC_DIV, FC_SQRT, FC_CVTWS, FC_FEQ, FC_FLT, FC_FLE, FC_CVTSW
    } fpuctrl_t;

    typedef struct packed {
        logic                valid;
        logic [TAGW_MAX-1:0] rd;
        fpuctrl_t            ctrl;
    } wb_slot_t;

    function automatic int op_latency(input fpuctrl_t ctrl, input int add_lat = 2, input int mul_lat = 2,
                                      input int div_lat = 10, input int sqrt_lat = 12,
                                      input int cvt_lat = 1, input int cmp_lat = 1);
        return ctrl inside {FC_ADD, FC_SUB} ? add_lat :
               ctrl == FC_MUL ? mul_lat :
               ctrl == FC_DIV ? div_lat :
               ctrl == FC_SQRT ? sqrt_lat :
               ctrl inside {FC_CVTWS, FC_CVTSW} ? cvt_lat : cmp_lat;
    endfunction

    function automatic int max_int(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/fpu_op_decode.sv
// fpu_op_decode: combinational funct7/funct3 decoder for the FPU datapath.
module fpu_op_decode
    import fpu_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output fpuctrl_t   fpucontrol,
    output logic       fpusrca,
    output logic       mode,
    output logic       is_iter,
    output logic       illegal
);
    logic cmp_ok;

    always_comb begin
        cmp_ok = funct3 inside {F3_FEQ, F3_FLT, F3_FLE};
        fpucontrol = FC_ADD;
        illegal = 1'b0;
        case (funct7)
            F7_FADD:   fpucontrol = FC_ADD;
            F7_FSUB:   fpucontrol = FC_SUB;
            F7_FMUL:   fpucontrol = FC_MUL;
            F7_FDIV:   fpucontrol = FC_DIV;
            F7_FSQRT:  fpucontrol = FC_SQRT;
            F7_FCVTWS: fpucontrol = FC_CVTWS;
            F7_FCVTSW: fpucontrol = FC_CVTSW;
            F7_FCMP: begin
                fpucontrol = funct3 == F3_FEQ ? FC_FEQ : funct3 == F3_FLT ? FC_FLT : funct3 == F3_FLE ? FC_FLE : FC_ADD;
                illegal = !cmp_ok;
            end
            default:   illegal = 1'b1;
        endcase
    end

    assign fpusrca = funct7 == F7_FCVTSW;
    assign mode    = funct7 == F7_FCVTWS && funct3 == 3'b010;
    assign is_iter = fpucontrol inside {FC_DIV, FC_SQRT};
endmodule

// File: rtl/fpu_issue_sched.sv
// fpu_issue_sched: FPU decode plus issue handshake over a writeback reservation shift register.
// Define FPU_PERF_CNT_EN to build the perf_issue/perf_stall counters.
module fpu_issue_sched
    import fpu_pkg::*;
#(
    parameter int ADD_LAT  = 2,
    parameter int MUL_LAT  = 2,
    parameter int DIV_LAT  = 10,
    parameter int SQRT_LAT = 12,
    parameter int CVT_LAT  = 1,
    parameter int CMP_LAT  = 1,
    parameter int TAGW     = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [TAGW-1:0] rd,
    input  logic            flush,
    output logic [3:0]      fpucontrol,
    output logic            fpusrca,
    output logic            mode,
    output logic            illegal,
    output logic            busy,
    output logic            wb_valid,
    output logic [TAGW-1:0] wb_rd,
    output logic [3:0]      wb_ctrl,
    output logic [31:0]     perf_issue,
    output logic [31:0]     perf_stall
);
    localparam int MAXLAT = max_int(max_int(max_int(ADD_LAT, MUL_LAT), max_int(DIV_LAT, SQRT_LAT)),
                                    max_int(CVT_LAT, CMP_LAT));
    localparam int IW = MAXLAT > 1 ? $clog2(MAXLAT) : 1;

    if (ADD_LAT < 1 || MUL_LAT < 1 || DIV_LAT < 1 || SQRT_LAT < 1 || CVT_LAT < 1 || CMP_LAT < 1 ||
        TAGW < 1 || TAGW > TAGW_MAX) begin : g_bad_cfg
        $error("fpu_issue_sched: every latency must be >= 1 and TAGW must fit wb_slot_t");
    end

    fpuctrl_t                ctrl;
    logic                    dec_illegal, is_iter, taken, accept, any_valid, iter_busy;
    int                      lat;
    wb_slot_t [MAXLAT-1:0]   res, shf, nxt;
    logic [IW-1:0]           cnt;

    fpu_op_decode u_dec (
        .funct3     (funct3),
        .funct7     (funct7),
        .fpucontrol (ctrl),
        .fpusrca    (fpusrca),
        .mode       (mode),
        .is_iter    (is_iter),
        .illegal    (dec_illegal)
    );

    // The iterative unit is free again on the cycle its result sits in slot 0.
    assign iter_busy = cnt != '0;

    always_comb begin
        shf = res >> $bits(wb_slot_t);
        lat = op_latency(ctrl, ADD_LAT, MUL_LAT, DIV_LAT, SQRT_LAT, CVT_LAT, CMP_LAT);
        taken = 1'b0;
        any_valid = 1'b0;
        for (int i = 0; i < MAXLAT; i++) begin
            taken |= (i == lat - 1) && shf[i].valid;
            any_valid |= res[i].valid;
        end
        in_ready = !flush && (dec_illegal || !(taken || (is_iter && iter_busy)));
        accept = in_valid && in_ready && !dec_illegal;
        nxt = shf;
        for (int i = 0; i < MAXLAT; i++)
            if (accept && i == lat - 1) nxt[i] = '{valid: 1'b1, rd: TAGW_MAX'(rd), ctrl: ctrl};
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            res <= '0;
            cnt <= '0;
            illegal <= 1'b0;
        end else begin
            res <= flush ? '0 : nxt;
            cnt <= flush ? '0 : (accept && is_iter) ? IW'(lat - 1) : cnt - IW'(iter_busy);
            illegal <= in_valid && in_ready && dec_illegal;
        end

    assign busy       = any_valid || iter_busy;
    assign wb_valid   = res[0].valid;
    assign wb_rd      = res[0].rd[TAGW-1:0];
    assign wb_ctrl    = res[0].ctrl;
    assign fpucontrol = ctrl;

`ifdef FPU_PERF_CNT_EN
    logic [31:0] issue_q, stall_q;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            issue_q <= '0;
            stall_q <= '0;
        end else begin
            issue_q <= issue_q + 32'(accept);
            stall_q <= stall_q + 32'(in_valid && !in_ready && !flush);
        end

    assign perf_issue = issue_q;
    assign perf_stall = stall_q;
`else
    assign perf_issue = '0;
    assign perf_stall = '0;
`endif
endmodule

// File: tb/tb_fpu_issue_sched.sv
// tb_fpu_issue_sched: scoreboard bench for fpu_issue_sched against a completion-cycle reference model.
module tb_fpu_issue_sched;
    localparam int TAGW = 5;

    typedef struct {
        int              acc;
        int              wb;
        logic [TAGW-1:0] rd;
        int              ctrl;
    } ent_t;

    logic            clk = 1'b0;
    logic            reset, in_valid, flush;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [TAGW-1:0] rd;
    logic            in_ready, fpusrca, mode, illegal, busy, wb_valid;
    logic [3:0]      fpucontrol, wb_ctrl;
    logic [TAGW-1:0] wb_rd;
    logic [31:0]     perf_issue, perf_stall;

    int   lat_tab [10] = '{2, 2, 2, 10, 12, 1, 1, 1, 1, 1};
    logic [6:0] ops [10] = '{7'b0000000, 7'b0000100, 7'b0001000, 7'b0001100, 7'b0101100,
                             7'b1100000, 7'b1010000, 7'b1101000, 7'b1111111, 7'b0000001};

    ent_t q[$];
    int   ill_q[$];
    int   cyc, checks, errors, iter_end, issue_cnt, stall_cnt;
    bit   last_fl, mon_en;

    always #5 clk = ~clk;

    fpu_issue_sched dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .funct7(funct7), .rd(rd), .flush(flush),
        .fpucontrol(fpucontrol), .fpusrca(fpusrca), .mode(mode), .illegal(illegal),
        .busy(busy), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_ctrl(wb_ctrl),
        .perf_issue(perf_issue), .perf_stall(perf_stall)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void ref_dec(input logic [6:0] f7, input logic [2:0] f3, output int c, output bit il);
        il = 1'b0;
        case (f7)
            7'b0000000: c = 0;
            7'b0000100: c = 1;
            7'b0001000: c = 2;
            7'b0001100: c = 3;
            7'b0101100: c = 4;
            7'b1100000: c = 5;
            7'b1101000: c = 9;
            7'b1010000: begin
                c = f3 == 3'b010 ? 6 : f3 == 3'b001 ? 7 : f3 == 3'b000 ? 8 : 0;
                il = f3 > 3'b010;
            end
            default: begin
                c = 0;
                il = 1'b1;
            end
        endcase
    endfunction

    function automatic bit slot_taken(input int t);
        foreach (q[i]) if (q[i].wb == t) return 1'b1;
        return 1'b0;
    endfunction

    // One cycle of stimulus: drive, predict in_ready from reserved completion cycles, record expectations.
    task automatic step(input bit v, input logic [6:0] f7, input logic [2:0] f3, input logic [TAGW-1:0] r,
                        input bit fl, output bit acc);
        int c, L;
        bit il, rdy, iter;
        if (last_fl) begin
            for (int i = q.size() - 1; i >= 0; i--) if (q[i].wb >= cyc) q.delete(i);
            iter_end = 0;
        end
        in_valid = v;
        funct7 = f7;
        funct3 = f3;
        rd = r;
        flush = fl;
        ref_dec(f7, f3, c, il);
        L = lat_tab[c];
        iter = !il && (c == 3 || c == 4);
        #2;
        chk("fpucontrol", int'(fpucontrol), c);
        chk("fpusrca", int'(fpusrca), int'(f7 == 7'b1101000));
        chk("mode", int'(mode), int'(f7 == 7'b1100000 && f3 == 3'b010));
        rdy = !fl && (il || (!slot_taken(cyc + L) && !(iter && iter_end > cyc)));
        chk("in_ready", int'(in_ready), int'(rdy));
        acc = v && rdy;
        if (acc && il) ill_q.push_back(cyc + 1);
        if (acc && !il) begin
            q.push_back('{cyc, cyc + L, r, c});
            issue_cnt++;
            if (iter) iter_end = cyc + L;
        end
        if (v && !rdy && !fl) stall_cnt++;
        last_fl = fl;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        bit a;
        repeat (n) step(1'b0, 7'b0, 3'b0, '0, 1'b0, a);
    endtask

    // Monitor: compares presented writebacks, busy and illegal against the scoreboard.
    always @(negedge clk) begin
        int idx;
        bit bz, il;
        if (mon_en && !reset) begin
            idx = -1;
            bz = 1'b0;
            foreach (q[i]) begin
                if (q[i].acc < cyc && q[i].wb >= cyc) bz = 1'b1;
                if (q[i].wb == cyc) idx = i;
            end
            chk("busy", int'(busy), int'(bz));
            chk("wb_valid", int'(wb_valid), int'(idx >= 0));
            if (idx >= 0) begin
                chk("wb_rd", int'(wb_rd), int'(q[idx].rd));
                chk("wb_ctrl", int'(wb_ctrl), q[idx].ctrl);
                q.delete(idx);
            end
            il = 1'b0;
            for (int i = ill_q.size() - 1; i >= 0; i--) begin
                if (ill_q[i] == cyc) il = 1'b1;
                if (ill_q[i] <= cyc) ill_q.delete(i);
            end
            chk("illegal", int'(illegal), int'(il));
        end
    end

    initial begin
        bit acc;
        int rel;
        reset = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        funct3 = '0;
        funct7 = '0;
        rd = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_valid", int'(wb_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_illegal", int'(illegal), 0);
        chk("rst_wb_rd", int'(wb_rd), 0);
        chk("rst_wb_ctrl", int'(wb_ctrl), 0);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_perf_issue", int'(perf_issue), 0);
        mon_en = 1'b1;
        // FADD rd=3 writes back exactly two cycles later
        step(1'b1, 7'b0000000, 3'b000, 5'd3, 1'b0, acc);
        idle(3);
        // FDIV then FSQRT: sqrt waits for the iterative unit
        step(1'b1, 7'b0001100, 3'b000, 5'd7, 1'b0, acc);
        rel = 0;
        do begin
            step(1'b1, 7'b0101100, 3'b000, 5'd9, 1'b0, acc);
            rel++;
        end while (!acc && rel < 30);
        chk("sqrt_accept_rel", rel, 10);
        idle(14);
        // FMUL then FEQ collide on the same writeback cycle
        step(1'b1, 7'b0001000, 3'b000, 5'd4, 1'b0, acc);
        rel = 0;
        do begin
            step(1'b1, 7'b1010000, 3'b010, 5'd5, 1'b0, acc);
            rel++;
        end while (!acc && rel < 30);
        chk("feq_accept_rel", rel, 2);
        idle(3);
        // unknown funct7 is consumed and flagged
        step(1'b1, 7'b1111111, 3'b000, 5'd6, 1'b0, acc);
        chk("illegal_ready", int'(acc), 1);
        idle(3);
        // flush kills an in-flight FDIV and frees the iterative unit
        step(1'b1, 7'b0001100, 3'b000, 5'd8, 1'b0, acc);
        idle(3);
        step(1'b0, 7'b0, 3'b0, '0, 1'b1, acc);
        step(1'b1, 7'b0001100, 3'b000, 5'd9, 1'b0, acc);
        chk("div_after_flush", int'(acc), 1);
        idle(20);
        // asynchronous reset in the middle of an FSQRT
        step(1'b1, 7'b0101100, 3'b000, 5'd10, 1'b0, acc);
        idle(5);
        reset = 1'b1;
        #1;
        chk("midrst_wb_valid", int'(wb_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_perf_issue", int'(perf_issue), 0);
        q.delete();
        ill_q.delete();
        iter_end = 0;
        last_fl = 1'b0;
        issue_cnt = 0;
        stall_cnt = 0;
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b0;
        // randomized traffic
        repeat (600) begin
            step($urandom_range(0, 9) < 7, ops[$urandom_range(0, 9)], 3'($urandom_range(0, 7)),
                 TAGW'($urandom), $urandom_range(0, 39) == 0, acc);
        end
        idle(20);
        chk("drain_empty", q.size(), 0);
`ifdef FPU_PERF_CNT_EN
        chk("perf_issue", int'(perf_issue), issue_cnt);
        chk("perf_stall", int'(perf_stall), stall_cnt);
`else
        chk("perf_issue_off", int'(perf_issue), 0);
        chk("perf_stall_off", int'(perf_stall), 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
